offset_add_stream: RTL and testbench

- Parametrised, registered successor to the team's fixed "add 3" combinational block.
- Adds a programmable offset to each input sample and returns the sum with an overflow flag.
- Runs on a valid/ready streaming interface, with a 2-entry output buffer so `in_ready` never depends combinationally on `out_ready`.
- Selectable wrap or saturate arithmetic; sticky overflow flag and delivered-result counter.
- Sits between a sample source and any consumer that can stall.

---
 rtl/offset_add_stream.sv | 131 +++++++++++++
 tb/tb_offset_add_stream.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/offset_add_stream.sv
// Streaming adder: adds a programmable offset to each sample, with wrap or saturate arithmetic.
// Results pass through a 2-entry buffer so in_ready never depends combinationally on out_ready.
module offset_add_stream #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned DEFAULT_OFFSET = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             offset_ld,
  input  logic [WIDTH-1:0] offset_in,
  input  logic             sat_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] res_count
);

  logic [WIDTH-1:0] offset_q, offset_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  // head_* is the entry presented on the output; tail_* is the second slot
  logic [WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic             head_ovf_q, head_ovf_d, tail_ovf_q, tail_ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] result;
  logic             push, pop;

  assign sum    = {1'b0, in_data} + {1'b0, offset_q};
  assign carry  = sum[WIDTH];
  assign result = (sat_mode && carry) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign push   = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;

  always_comb begin
    offset_d    = offset_ld ? offset_in : offset_q;
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_ovf_d  = head_ovf_q;
    tail_data_d = tail_data_q;
    tail_ovf_d  = tail_ovf_q;

    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_data_d = result;
          head_ovf_d  = carry;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = result;
          head_ovf_d  = carry;
        end else if (push) begin
          tail_data_d = result;
          tail_ovf_d  = carry;
          cnt_d       = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        // in_ready is low when full, so only a pop can occur here
        if (pop) begin
          head_data_d = tail_data_q;
          head_ovf_d  = tail_ovf_q;
          cnt_d       = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase

    in_ready_d  = (cnt_d < 2'd2);
    out_valid_d = (cnt_d != 2'd0);

    sticky_d = sticky_q;
    if (push && carry) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end

    res_count_d = pop ? res_count_q + CNT_W'(1) : res_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q    <= WIDTH'(DEFAULT_OFFSET);
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_data_q <= '0;
      head_ovf_q  <= 1'b0;
      tail_data_q <= '0;
      tail_ovf_q  <= 1'b0;
      sticky_q    <= 1'b0;
      res_count_q <= '0;
    end else begin
      offset_q    <= offset_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_data_q <= head_data_d;
      head_ovf_q  <= head_ovf_d;
      tail_data_q <= tail_data_d;
      tail_ovf_q  <= tail_ovf_d;
      sticky_q    <= sticky_d;
      res_count_q <= res_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = head_data_q;
  assign out_ovf    = head_ovf_q;
  assign ovf_sticky = sticky_q;
  assign res_count  = res_count_q;

endmodule

// File: tb/tb_offset_add_stream.sv
// Directed bench for offset_add_stream: a driver pushes hand-computed results into a
// scoreboard queue, and an independent monitor pops and compares on each delivered result.
module tb_offset_add_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       offset_ld = 1'b0;
  logic [3:0] offset_in = '0;
  logic       sat_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       in_ready, out_valid, out_ovf, ovf_sticky;
  logic [3:0] out_data;
  logic [7:0] res_count;
  logic       in_ready2, out_valid2, out_ovf2, ovf_sticky2;
  logic [3:0] out_data2;
  logic [1:0] res_count2;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] sb[$];         // {ovf, data}
  int         m_cnt = 0;
  logic       m_sticky = 1'b0;
  logic [4:0] last_out = '0;
  logic       mon_en = 1'b0;
  logic [3:0] cur_data = '0;
  logic       cur_ovf = 1'b0;

  always #5 clk = ~clk;

  offset_add_stream #(.WIDTH(4), .DEFAULT_OFFSET(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .offset_ld(offset_ld), .offset_in(offset_in), .sat_mode(sat_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr), .res_count(res_count)
  );

  // Narrow-counter instance sharing the same stimulus, for the counter wrap behaviour
  offset_add_stream #(.WIDTH(4), .DEFAULT_OFFSET(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .offset_ld(offset_ld), .offset_in(offset_in), .sat_mode(sat_mode),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_ovf(out_ovf2), .ovf_sticky(ovf_sticky2),
    .ovf_clr(ovf_clr), .res_count(res_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock edge: record an accept and track the sticky flag, then step off the edge
  task automatic tick(output bit acc);
    @(posedge clk);
    acc = in_valid && in_ready && !rst;
    if (rst) m_sticky = 1'b0;
    else if (acc && cur_ovf) m_sticky = 1'b1;
    else if (ovf_clr) m_sticky = 1'b0;
    if (acc) sb.push_back({cur_ovf, cur_data});
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send(input logic [3:0] d, input logic sat, input logic [3:0] ed, input logic eo);
    bit acc;
    int waited;
    in_data  = d;
    sat_mode = sat;
    in_valid = 1'b1;
    cur_data = ed;
    cur_ovf  = eo;
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited < 40) begin
      tick(acc);
      waited++;
    end
    if (!acc) check("accept_timeout", 32'(waited), 32'(0));
    in_valid  = 1'b0;
    offset_ld = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() > 0 && waited < 40) begin
      idle(1);
      waited++;
    end
    check("drain_left", 32'(sb.size()), 32'(0));
  endtask

  // Monitor: retire results at the edge where they are delivered
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      m_cnt    = 0;
      last_out = '0;
    end else if (mon_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'(99));
      end else begin
        last_out = sb.pop_front();
        m_cnt++;
      end
    end
  end

  // Monitor: compare everything visible mid-cycle against the scoreboard state
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      check("res_count", 32'(res_count), 32'(m_cnt % 256));
      check("res_count_w2", 32'(res_count2), 32'(m_cnt % 4));
      check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
      if (sb.size() > 0) begin
        check("out_data", 32'(out_data), 32'(sb[0][3:0]));
        check("out_ovf", 32'(out_ovf), 32'(sb[0][4]));
      end else begin
        check("out_data_hold", 32'(out_data), 32'(last_out[3:0]));
        check("out_ovf_hold", 32'(out_ovf), 32'(last_out[4]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    idle(2);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(1);
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_out_data", 32'(out_data), 32'(0));

    // Stream 0..9 through offset 3, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(4'(i), 1'b0, 4'(i + 3), 1'b0);
    drain();
    check("res_count_after_stream", 32'(res_count), 32'(10));

    // Overflow in wrap then saturate mode, then clear the sticky flag
    send(4'd13, 1'b0, 4'd0, 1'b1);
    send(4'd13, 1'b1, 4'd15, 1'b1);
    drain();
    check("sticky_set", 32'(ovf_sticky), 32'(1));
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("sticky_cleared", 32'(ovf_sticky), 32'(0));

    // Backpressure: two accepts fill the buffer, the third sample is held
    out_ready = 1'b0;
    send(4'd1, 1'b0, 4'd4, 1'b0);
    send(4'd2, 1'b0, 4'd5, 1'b0);
    in_data  = 4'd3;
    cur_data = 4'd6;
    cur_ovf  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check("full_no_accept", 32'(acc), 32'(0));
    end
    check("full_in_ready", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    send(4'd3, 1'b0, 4'd6, 1'b0);
    drain();

    // Offset load takes effect after the accepting edge; reset restores the default
    offset_ld = 1'b1;
    offset_in = 4'd7;
    send(4'd1, 1'b0, 4'd4, 1'b0);
    send(4'd1, 1'b0, 4'd8, 1'b0);
    drain();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(4'd1, 1'b0, 4'd4, 1'b0);
    drain();

    // Reset while full discards the buffered results
    out_ready = 1'b0;
    send(4'd14, 1'b0, 4'd1, 1'b1);
    send(4'd6, 1'b0, 4'd9, 1'b0);
    check("full_before_reset", 32'(in_ready), 32'(0));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_res_count", 32'(res_count), 32'(0));
    check("rst_sticky", 32'(ovf_sticky), 32'(0));
    out_ready = 1'b1;
    send(4'd2, 1'b0, 4'd5, 1'b0);
    drain();

    // Four more results: narrow counter runs 1,2,3,0,1
    for (int i = 0; i < 4; i++) send(4'(i), 1'b0, 4'(i + 3), 1'b0);
    drain();
    check("res_count_w2_wrapped", 32'(res_count2), 32'(1));
    check("res_count_five", 32'(res_count), 32'(5));

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
